// File: rtl/rotor_stage.sv
// Enigma rotor stage: ring/position-offset permutation of one symbol per valid/ready handshake.
// Latency 1 cycle; single output register, in_ready drops while an unaccepted result is held.
module rotor_stage #(
  parameter int N = 26,
  parameter int W = 5,
  parameter logic [N*W-1:0] WIRING = {
    5'd6,  5'd11, 5'd13, 5'd8,  5'd3,  5'd12, 5'd5,  5'd4,  5'd2,
    5'd7,  5'd9,  5'd16, 5'd1,  5'd23, 5'd25, 5'd15, 5'd17, 5'd21,
    5'd24, 5'd20, 5'd0,  5'd18, 5'd10, 5'd19, 5'd14, 5'd22},
  parameter int NOTCH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_load,
  input  logic [W-1:0] pos_in,
  input  logic [W-1:0] ring_in,
  input  logic         step,
  output logic         carry_out,
  output logic [W-1:0] position,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dir,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  localparam logic [W:0]   NW    = (W+1)'(N);
  localparam logic [W-1:0] LAST  = W'(N-1);
  localparam logic [W-1:0] NOTCH_POS = W'(NOTCH);

  function automatic bit wiring_ok();
    logic [N-1:0] seen;
    seen = '0;
    for (int i = 0; i < N; i++) begin
      int v;
      v = int'(WIRING[W*i +: W]);
      if (v >= N) return 1'b0;
      if (seen[v]) return 1'b0;
      seen[v] = 1'b1;
    end
    return 1'b1;
  endfunction

  if (!wiring_ok()) begin : g_bad_wiring
    $error("rotor_stage: WIRING is not a permutation of 0..N-1");
  end

  // Operands are < N, so one conditional subtract completes the reduction.
  function automatic logic [W-1:0] mod_n(input logic [W:0] x);
    return (x >= NW) ? W'(x - NW) : W'(x);
  endfunction

  logic [W-1:0] ring;
  logic [W-1:0] fwd_tab [N];
  logic [W-1:0] inv_tab [N];

  for (genvar i = 0; i < N; i++) begin : g_tab
    assign fwd_tab[i] = WIRING[W*i +: W];
    assign inv_tab[WIRING[W*i +: W]] = W'(i);
  end

  logic         in_err;
  logic [W-1:0] off;
  logic [W-1:0] idx;
  logic [W-1:0] tab_v;
  logic [W-1:0] res;

  always_comb begin
    in_err = ({1'b0, in_data} >= NW);
    off    = mod_n({1'b0, position} + NW - {1'b0, ring});
    idx    = in_err ? '0 : mod_n({1'b0, in_data} + {1'b0, off});
    tab_v  = in_dir ? inv_tab[idx] : fwd_tab[idx];
    res    = mod_n({1'b0, tab_v} + NW - {1'b0, off});
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position  <= '0;
      ring      <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (cfg_load) begin
        position <= W'(int'(pos_in) % N);
        ring     <= W'(int'(ring_in) % N);
      end else if (step) begin
        position  <= (position == LAST) ? '0 : position + 1'b1;
        carry_out <= (position == NOTCH_POS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_err ? '0 : res;
      out_err   <= in_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Bench for rotor_stage: table vectors, round trips, stepping, backpressure, error and reset sequences.
module tb_rotor_stage;
  localparam int N = 26;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load = 1'b0;
  logic [W-1:0] pos_in = '0;
  logic [W-1:0] ring_in = '0;
  logic         step = 1'b0;
  logic         carry_out;
  logic [W-1:0] position;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_dir = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_err;

  always #5 clk = ~clk;

  rotor_stage dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .pos_in(pos_in), .ring_in(ring_in),
    .step(step), .carry_out(carry_out), .position(position),
    .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  typedef struct packed { logic [W-1:0] d; logic e; } res_t;
  typedef struct { bit dir; int s; int p; int r; int d; bit e; } vec_t;

  res_t sb[$];
  res_t nxt_exp;
  int   n_vec = 0;
  int   n_err = 0;
  int   mpos = 0;
  int   mring = 0;
  bit   mcarry = 1'b0;
  bit   mvld = 1'b0;
  int   wir[N] = '{22,14,19,10,18,0,20,24,21,17,15,25,23,1,16,9,7,2,4,5,12,3,8,13,11,6};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int inv(input int v);
    for (int i = 0; i < N; i++) if (wir[i] == v) return i;
    return -1;
  endfunction

  function automatic res_t mdl(input bit dir, input int s, input int p, input int r);
    res_t t;
    int off, idx, v;
    if (s >= N) begin
      t.d = '0; t.e = 1'b1;
      return t;
    end
    off = (p - r + N) % N;
    idx = (s + off) % N;
    v   = dir ? inv(idx) : wir[idx];
    t.d = W'((v - off + N) % N);
    t.e = 1'b0;
    return t;
  endfunction

  // Inputs are set at the falling edge; the checks run 1 time unit later, then the
  // model advances to what the next rising edge will do.
  task automatic tick();
    bit fin;
    #1;
    chk("position", 32'(position), 32'(mpos));
    chk("carry_out", 32'(carry_out), 32'(mcarry));
    chk("out_valid", 32'(out_valid), 32'(mvld));
    chk("in_ready", 32'(in_ready), 32'(!mvld || out_ready));
    if (mvld && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard: output delivered with nothing expected (got %0d)", out_data);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_err", 32'(out_err), 32'(e.e));
      end
    end
    fin = in_valid && (!mvld || out_ready);
    if (fin) sb.push_back(nxt_exp);
    mvld   = fin ? 1'b1 : (out_ready ? 1'b0 : mvld);
    mcarry = step && !cfg_load && (mpos == 16);
    if (cfg_load) begin
      mpos  = int'(pos_in) % N;
      mring = int'(ring_in) % N;
    end else if (step) begin
      mpos = (mpos == N-1) ? 0 : mpos + 1;
    end
    @(negedge clk);
  endtask

  task automatic send(input bit dir, input int s, input res_t e);
    in_valid = 1'b1; in_dir = dir; in_data = W'(s); nxt_exp = e;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic load(input int p, input int r);
    in_valid = 1'b0; cfg_load = 1'b1; pos_in = W'(p); ring_in = W'(r);
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    vec_t vt[12];
    vt[0]  = '{0, 0, 0, 0, 22, 0};
    vt[1]  = '{1, 22, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 1, 0, 13, 0};
    vt[3]  = '{1, 13, 1, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 7, 0};
    vt[5]  = '{1, 7, 0, 1, 0, 0};
    vt[6]  = '{0, 10, 5, 2, 24, 0};
    vt[7]  = '{1, 24, 5, 2, 10, 0};
    vt[8]  = '{0, 26, 3, 0, 0, 1};
    vt[9]  = '{0, 1, 25, 0, 23, 0};
    vt[10] = '{1, 31, 25, 0, 0, 1};
    vt[11] = '{1, 23, 25, 0, 1, 0};

    @(negedge clk);
    chk("rst_position", 32'(position), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 12; i++) begin
      load(vt[i].p, vt[i].r);
      send(vt[i].dir, vt[i].s, '{W'(vt[i].d), vt[i].e});
      idle();
    end

    for (int p = 0; p < N; p++) begin
      load(p, (p * 7) % N);
      for (int s = 0; s < N; s++) begin
        res_t e;
        e = mdl(1'b0, s, mpos, mring);
        send(1'b0, s, e);
        send(1'b1, int'(e.d), '{W'(s), 1'b0});
      end
    end
    idle();

    load(25, 0);
    step = 1'b1; idle(); step = 1'b0;
    chk("wrap_position", 32'(position), 32'd0);
    chk("wrap_carry", 32'(carry_out), 32'd0);
    load(16, 0);
    step = 1'b1; idle(); step = 1'b0;
    chk("notch_position", 32'(position), 32'd17);
    chk("carry_pulse", 32'(carry_out), 32'd1);
    idle();
    chk("carry_drop", 32'(carry_out), 32'd0);
    load(16, 0);
    cfg_load = 1'b1; pos_in = W'(4); step = 1'b1;
    in_valid = 1'b0; tick();
    cfg_load = 1'b0; step = 1'b0;
    chk("load_wins_pos", 32'(position), 32'd4);
    chk("load_wins_carry", 32'(carry_out), 32'd0);

    load(0, 0);
    out_ready = 1'b0;
    send(1'b0, 0, '{W'(22), 1'b0});
    send(1'b0, 5, '{W'(0), 1'b0});
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_held_data", 32'(out_data), 32'd22);
    send(1'b0, 5, '{W'(0), 1'b0});
    chk("bp_held_data2", 32'(out_data), 32'd22);
    out_ready = 1'b1;
    send(1'b0, 5, '{W'(0), 1'b0});
    idle();
    idle();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    send(1'b0, 26, '{W'(0), 1'b1});
    send(1'b0, 0, '{W'(22), 1'b0});
    idle();
    idle();

    load(7, 0);
    out_ready = 1'b0;
    send(1'b0, 3, mdl(1'b0, 3, 7, 0));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_position", 32'(position), 32'd0);
    sb.delete();
    mpos = 0; mring = 0; mvld = 1'b0; mcarry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle();
    send(1'b0, 0, '{W'(22), 1'b0});
    idle();
    idle();
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
